eth_tx_framer: RTL and testbench

Parametrised Ethernet II transmit framer and the next-generation replacement for the fixed-format frame transmitter. It takes a header plus a variable-length byte-stream payload and produces one byte per cycle toward the MII/GMII byte interface, in this order: preamble, SFD, header, payload, zero padding, real CRC-32 FCS. It then enforces the inter-frame gap. It sits between the MAC TX buffer (payload source) and the PHY-side serialiser.

---
 rtl/eth_tx_framer.sv | 203 ++++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// Ethernet II transmit framer: preamble, SFD, header, streamed payload, zero pad
// and CRC-32 FCS, one registered byte per cycle, followed by the inter-frame gap.
module eth_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 46,
  parameter int MAX_PAYLOAD  = 1500,
  parameter int IFG_BYTES    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [47:0] dest_addr,
  input  logic [47:0] src_addr,
  input  logic [15:0] eth_type,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        tx_done,
  output logic        tx_err,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, SFD, DEST, SRC, TYPE, PAYLOAD, PAD, FCS, IFG
  } state_t;

  localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN - 1);
  localparam logic [10:0] MAX_CNT  = 11'(MAX_PAYLOAD);
  localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);

  state_t      state, state_n;
  logic [10:0] cnt, cnt_n;
  logic [10:0] pad_last, pad_last_n;
  logic [31:0] crc, crc_n;
  logic [47:0] dest_q, src_q;
  logic [15:0] type_q;
  logic [7:0]  data_n;
  logic        en_n, done_n, err_n, latch;
  logic [47:0] dest_sh, src_sh;
  logic [31:0] fcs_sh;

  function automatic logic [31:0] crc_update(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Header and FCS bytes are picked by shifting so the counter selects MSB-first / low-first.
  assign dest_sh = dest_q << {cnt[2:0], 3'b000};
  assign src_sh  = src_q << {cnt[2:0], 3'b000};
  assign fcs_sh  = ~crc >> {cnt[1:0], 3'b000};

  // The count==MAX cycle is the oversize abort, so nothing is consumed then.
  assign s_ready = (state == PAYLOAD) && (cnt != MAX_CNT);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt + 11'd1;
    pad_last_n = pad_last;
    crc_n      = crc;
    data_n     = 8'h00;
    en_n       = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    latch      = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) begin
          state_n = PREAMBLE;
          latch   = 1'b1;
          crc_n   = 32'hFFFFFFFF;
        end
      end
      PREAMBLE: begin
        data_n = 8'h55;
        en_n   = 1'b1;
        if (cnt == PRE_LAST) begin
          state_n = SFD;
          cnt_n   = '0;
        end
      end
      SFD: begin
        data_n  = 8'hD5;
        en_n    = 1'b1;
        state_n = DEST;
        cnt_n   = '0;
      end
      DEST: begin
        data_n = dest_sh[47:40];
        en_n   = 1'b1;
        crc_n  = crc_update(crc, data_n);
        if (cnt == 11'd5) begin
          state_n = SRC;
          cnt_n   = '0;
        end
      end
      SRC: begin
        data_n = src_sh[47:40];
        en_n   = 1'b1;
        crc_n  = crc_update(crc, data_n);
        if (cnt == 11'd5) begin
          state_n = TYPE;
          cnt_n   = '0;
        end
      end
      TYPE: begin
        data_n = cnt[0] ? type_q[7:0] : type_q[15:8];
        en_n   = 1'b1;
        crc_n  = crc_update(crc, data_n);
        if (cnt == 11'd1) begin
          state_n = PAYLOAD;
          cnt_n   = '0;
        end
      end
      PAYLOAD: begin
        if (cnt == MAX_CNT || !s_valid) begin
          err_n   = 1'b1;
          state_n = IFG;
          cnt_n   = '0;
        end else begin
          data_n = s_data;
          en_n   = 1'b1;
          crc_n  = crc_update(crc, s_data);
          if (s_last) begin
            cnt_n = '0;
            if (32'(cnt) + 32'd1 < 32'(MIN_PAYLOAD)) begin
              state_n    = PAD;
              pad_last_n = 11'(32'(MIN_PAYLOAD) - 32'd2 - 32'(cnt));
            end else begin
              state_n = FCS;
            end
          end
        end
      end
      PAD: begin
        en_n  = 1'b1;
        crc_n = crc_update(crc, 8'h00);
        if (cnt == pad_last) begin
          state_n = FCS;
          cnt_n   = '0;
        end
      end
      FCS: begin
        data_n = fcs_sh[7:0];
        en_n   = 1'b1;
        if (cnt == 11'd3) begin
          done_n  = 1'b1;
          state_n = IFG;
          cnt_n   = '0;
        end
      end
      IFG: begin
        if (cnt == IFG_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pad_last <= '0;
      crc      <= 32'hFFFFFFFF;
      dest_q   <= '0;
      src_q    <= '0;
      type_q   <= '0;
      tx_data  <= 8'h00;
      tx_en    <= 1'b0;
      tx_done  <= 1'b0;
      tx_err   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pad_last <= pad_last_n;
      crc      <= crc_n;
      tx_data  <= data_n;
      tx_en    <= en_n;
      tx_done  <= done_n;
      tx_err   <= err_n;
      busy     <= (state_n != IDLE);
      if (latch) begin
        dest_q <= dest_addr;
        src_q  <= src_addr;
        type_q <= eth_type;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: expected wire bytes are queued when a frame
// is launched and popped as tx_en bytes appear; framing timing is checked directly.
module tb_eth_tx_framer;

  localparam int PRE  = 7;
  localparam int MINP = 46;
  localparam int MAXP = 1500;
  localparam int IFG  = 12;
  localparam int HDR  = PRE + 1 + 14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [47:0] dest_addr, src_addr;
  logic [15:0] eth_type;
  logic [7:0]  s_data;
  logic        s_valid, s_last;
  logic        s_ready;
  logic [7:0]  tx_data;
  logic        tx_en, tx_done, tx_err, busy;

  eth_tx_framer #(
    .PREAMBLE_LEN(PRE), .MIN_PAYLOAD(MINP), .MAX_PAYLOAD(MAXP), .IFG_BYTES(IFG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dest_addr(dest_addr), .src_addr(src_addr), .eth_type(eth_type),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .tx_data(tx_data), .tx_en(tx_en), .tx_done(tx_done), .tx_err(tx_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] frame_bytes[$];
  int en_count = 0;
  int done_cnt = 0;
  logic prev_en = 1'b0;

  logic [7:0] pay_mem [0:4095];
  bit         last_mem [0:4095];
  int pay_len = 0;
  int underrun_at = -1;
  int feed_idx = 0;
  bit hs = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crcModel(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Monitor: every tx_en byte is matched against the scoreboard head.
  always @(negedge clk) begin
    if (tx_en && !prev_en) begin
      en_count = 0;
      frame_bytes.delete();
    end
    if (tx_en) begin
      en_count++;
      frame_bytes.push_back(tx_data);
      if (exp_q.size() == 0) checkOutput("unexpected_tx_en", {31'd0, tx_en}, 32'd0);
      else                   checkOutput("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
    end
    if (tx_done) done_cnt++;
    hs = s_ready && s_valid;
    prev_en = tx_en;
  end

  // Payload source: presents the next byte once the previous one was handshaked.
  always @(posedge clk) begin
    #1;
    if (hs) feed_idx++;
    s_valid = (feed_idx < pay_len) && (feed_idx != underrun_at);
    s_data  = pay_mem[feed_idx];
    s_last  = s_valid && last_mem[feed_idx];
  end

  task automatic feedSetup(input int len, input int underrun, input int base, input int last_every);
    @(negedge clk);
    for (int i = 0; i < 4096; i++) begin
      pay_mem[i]  = 8'(base + i);
      last_mem[i] = (last_every != 0) && ((i % last_every) == last_every - 1);
    end
    pay_len     = len;
    underrun_at = underrun;
    feed_idx    = 0;
  endtask

  task automatic pushFrame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                           input int first, input int n, input bit complete);
    logic [7:0]  body[$];
    logic [31:0] c;
    for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 6; i++) body.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) body.push_back(s[47-8*i -: 8]);
    body.push_back(t[15:8]);
    body.push_back(t[7:0]);
    for (int i = 0; i < n; i++) body.push_back(pay_mem[first+i]);
    if (complete) while (body.size() < 14 + MINP) body.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (body[i]) begin
      c = crcModel(c, body[i]);
      exp_q.push_back(body[i]);
    end
    if (complete) begin
      c = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    end
  endtask

  task automatic applyStimulus(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                               input int first, input int n, input bit complete);
    pushFrame(d, s, t, first, n, complete);
    @(posedge clk); #1;
    dest_addr = d;
    src_addr  = s;
    eth_type  = t;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // kind: 1 = tx_done seen, 2 = tx_err seen, 0 = bound expired
  task automatic waitFrameEnd(input int budget, output int kind);
    kind = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_done) begin kind = 1; break; end
      if (tx_err)  begin kind = 2; break; end
    end
    if (kind == 0) checkOutput("frame_end_timeout", {31'd0, tx_done | tx_err}, 32'd1);
  endtask

  task automatic countBusyFall(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (!busy) begin n = i; break; end
    end
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int kind, n, done_before;
    logic [31:0] c;
    logic [7:0] hdr_exp [14];

    rst_n = 1'b0; start = 1'b0;
    dest_addr = '0; src_addr = '0; eth_type = '0;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("rst_tx_en",   {31'd0, tx_en},   32'd0);
    checkOutput("rst_tx_done", {31'd0, tx_done}, 32'd0);
    checkOutput("rst_tx_err",  {31'd0, tx_err},  32'd0);
    checkOutput("rst_busy",    {31'd0, busy},    32'd0);
    checkOutput("rst_s_ready", {31'd0, s_ready}, 32'd0);
    rst_n = 1'b1;

    $display("[TB] minimum frame");
    feedSetup(1, -1, 8'hAB, 1);
    applyStimulus(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h88B5, 0, 1, 1'b1);
    @(negedge clk);
    checkOutput("latency_busy", {31'd0, busy}, 32'd1);
    checkOutput("latency_en_low", {31'd0, tx_en}, 32'd0);
    @(negedge clk);
    checkOutput("latency_first_en", {31'd0, tx_en}, 32'd1);
    checkOutput("latency_first_byte", {24'd0, tx_data}, 32'h55);
    waitFrameEnd(200, kind);
    #1;
    checkOutput("min_end_kind", kind, 32'd1);
    checkOutput("min_en_cycles", en_count, 32'(HDR + MINP + 4));
    checkOutput("min_payload_byte", {24'd0, frame_bytes[HDR]}, 32'hAB);
    countBusyFall(50, n);
    checkOutput("min_busy_fall", n, 32'(IFG));
    checkOutput("min_drained", exp_q.size(), 32'd0);

    $display("[TB] FCS and header order");
    feedSetup(60, -1, 0, 60);
    applyStimulus(48'h0102_0304_0506, 48'h0A0B_0C0D_0E0F, 16'h0800, 0, 60, 1'b1);
    waitFrameEnd(200, kind);
    #1;
    checkOutput("fcs_end_kind", kind, 32'd1);
    checkOutput("fcs_en_cycles", en_count, 32'(HDR + 60 + 4));
    c = 32'hFFFFFFFF;
    for (int i = PRE + 1; i < frame_bytes.size(); i++) c = crcModel(c, frame_bytes[i]);
    checkOutput("fcs_residue", c, 32'hDEBB20E3);
    checkOutput("sfd_byte", {24'd0, frame_bytes[PRE]}, 32'hD5);
    hdr_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h08, 8'h00};
    for (int i = 0; i < 14; i++)
      checkOutput("hdr_byte", {24'd0, frame_bytes[PRE+1+i]}, {24'd0, hdr_exp[i]});
    countBusyFall(50, n);
    checkOutput("fcs_drained", exp_q.size(), 32'd0);

    $display("[TB] underrun");
    done_before = done_cnt;
    feedSetup(50, 10, 8'h10, 50);
    applyStimulus(48'h1111_2222_3333, 48'h4444_5555_6666, 16'h0800, 0, 10, 1'b0);
    waitFrameEnd(200, kind);
    checkOutput("urun_err_en", {31'd0, tx_en}, 32'd0);
    #1;
    checkOutput("urun_end_kind", kind, 32'd2);
    checkOutput("urun_en_cycles", en_count, 32'(HDR + 10));
    @(negedge clk);
    checkOutput("urun_err_pulse", {31'd0, tx_err}, 32'd0);
    countBusyFall(50, n);
    checkOutput("urun_busy_fall", n, 32'(IFG - 1));
    checkOutput("urun_no_done", done_cnt, done_before);
    checkOutput("urun_drained", exp_q.size(), 32'd0);

    $display("[TB] oversize");
    done_before = done_cnt;
    feedSetup(MAXP + 1, -1, 0, 0);
    applyStimulus(48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 16'h86DD, 0, MAXP, 1'b0);
    waitFrameEnd(2000, kind);
    checkOutput("ovs_err_en", {31'd0, tx_en}, 32'd0);
    #1;
    checkOutput("ovs_end_kind", kind, 32'd2);
    checkOutput("ovs_en_cycles", en_count, 32'(HDR + MAXP));
    checkOutput("ovs_no_done", done_cnt, done_before);
    countBusyFall(50, n);
    feedSetup(5, -1, 8'hC0, 5);
    applyStimulus(48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 16'h0800, 0, 5, 1'b1);
    waitFrameEnd(200, kind);
    #1;
    checkOutput("ovs_next_kind", kind, 32'd1);
    checkOutput("ovs_next_en_cycles", en_count, 32'(HDR + MINP + 4));
    countBusyFall(50, n);
    checkOutput("ovs_drained", exp_q.size(), 32'd0);

    $display("[TB] back-to-back");
    feedSetup(200, -1, 8'h40, 100);
    pushFrame(48'h0050_5600_0001, 48'h0050_5600_0002, 16'h0800, 0, 100, 1'b1);
    pushFrame(48'h0050_5600_0001, 48'h0050_5600_0002, 16'h0800, 100, 100, 1'b1);
    @(posedge clk); #1;
    dest_addr = 48'h0050_5600_0001;
    src_addr  = 48'h0050_5600_0002;
    eth_type  = 16'h0800;
    start     = 1'b1;
    waitFrameEnd(400, kind);
    #1;
    checkOutput("b2b_first_kind", kind, 32'd1);
    checkOutput("b2b_first_len", en_count, 32'(HDR + 100 + 4));
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (tx_en) begin n = i; break; end
    end
    checkOutput("b2b_gap", n, 32'(IFG + 2));
    @(posedge clk); #1;
    start = 1'b0;
    waitFrameEnd(400, kind);
    #1;
    checkOutput("b2b_second_kind", kind, 32'd1);
    checkOutput("b2b_second_len", en_count, 32'(HDR + 100 + 4));
    countBusyFall(50, n);
    checkOutput("b2b_busy_fall", n, 32'(IFG));
    checkOutput("b2b_drained", exp_q.size(), 32'd0);

    $display("[TB] reset mid-payload");
    feedSetup(50, -1, 8'h20, 50);
    applyStimulus(48'hDEAD_BEEF_0001, 48'hDEAD_BEEF_0002, 16'h0800, 0, 50, 1'b1);
    n = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_ready) begin n = i; break; end
    end
    checkOutput("rst_reach_payload", {31'd0, s_ready}, 32'd1);
    repeat (5) @(negedge clk);
    done_before = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("mid_rst_tx_en",   {31'd0, tx_en},   32'd0);
    checkOutput("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("mid_rst_busy",    {31'd0, busy},    32'd0);
    checkOutput("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
    checkOutput("mid_rst_tx_done", {31'd0, tx_done}, 32'd0);
    checkOutput("mid_rst_tx_err",  {31'd0, tx_err},  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("mid_rst_no_done", done_cnt, done_before);
    checkOutput("mid_rst_idle_busy", {31'd0, busy}, 32'd0);
    feedSetup(3, -1, 8'h70, 3);
    applyStimulus(48'h0102_0304_0506, 48'h0A0B_0C0D_0E0F, 16'h0806, 0, 3, 1'b1);
    waitFrameEnd(200, kind);
    #1;
    checkOutput("post_rst_kind", kind, 32'd1);
    checkOutput("post_rst_len", en_count, 32'(HDR + MINP + 4));
    countBusyFall(50, n);
    checkOutput("post_rst_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
